// File: rtl/shift_16b_pkg.sv
// Shared constants and helpers for the 16-bit barrel shifter.
// SHIFT16B_ROTATE_EN enables rotate-left on dir=0, mode=1.
package shift_pkg;
    localparam int WIDTH = 16;
    localparam int AMT_W = 5;

    localparam logic DIR_LEFT   = 1'b0;
    localparam logic DIR_RIGHT  = 1'b1;
    localparam logic MODE_LOG   = 1'b0;
    localparam logic MODE_ARITH = 1'b1;

    // Rotate left modulo WIDTH: the upper half of the doubled word after shifting.
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] d, input logic [3:0] n);
        logic [2*WIDTH-1:0] t;
        t = {d, d} << n;
        return t[2*WIDTH-1:WIDTH];
    endfunction
endpackage

// File: rtl/shift_16b_if.sv
// Operand/result bundle between the execute stage and the shifter.
interface shift_16b_if;
    import shift_pkg::*;

    logic [WIDTH-1:0] in;
    logic [AMT_W-1:0] amt;
    logic             mode;
    logic             dir;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic             out_valid;

    modport master (output in, amt, mode, dir, in_valid, input out, out_valid);
    modport slave  (input in, amt, mode, dir, in_valid, output out, out_valid);
endinterface

// File: rtl/shift_16b_stage.sv
// One barrel stage: conditionally shifts by SHIFT bits left (zero fill) or right (fill bit).
module shift16b_stage
    import shift_pkg::*;
#(
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en,
    input  logic             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] data_o
);
    always_comb begin
        data_o = data_i;
        if (en) begin
            if (dir == DIR_LEFT) data_o = {data_i[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
            else                 data_o = {{SHIFT{fill}}, data_i[WIDTH-1:SHIFT]};
        end
    end
endmodule

// File: rtl/shift_16b.sv
// Registered 16-bit barrel shifter (SLL/SRL/SRA, amt 0..31), one cycle of latency.
// Optional SHIFT16B_ROTATE_EN: dir=0, mode=1 rotates left by amt[3:0].
module shift_16b
    import shift_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    shift_16b_if.slave  bus
);
    logic [4:0][WIDTH-1:0] stg;
    logic                  fill;
    logic [WIDTH-1:0]      shift_res;
    logic [WIDTH-1:0]      out_d, out_q;
    logic                  out_valid_d, out_valid_q;

    // Only arithmetic right shifts of a negative operand fill with ones.
    assign fill   = bus.mode & bus.dir & bus.in[WIDTH-1];
    assign stg[0] = bus.in;

    for (genvar i = 0; i < 4; i++) begin : g_stage
        shift16b_stage #(.SHIFT(1 << i)) u_stage (
            .data_i (stg[i]),
            .en     (bus.amt[i]),
            .dir    (bus.dir),
            .fill   (fill),
            .data_o (stg[i+1])
        );
    end

    always_comb begin
        // amt >= 16 moves every operand bit out; only the fill remains.
        shift_res = bus.amt[4] ? {WIDTH{fill}} : stg[4];
`ifdef SHIFT16B_ROTATE_EN
        if (bus.dir == DIR_LEFT && bus.mode == MODE_ARITH)
            shift_res = rotl(bus.in, bus.amt[3:0]);
`endif
    end

    always_comb begin
        out_d       = bus.in_valid ? shift_res : out_q;
        out_valid_d = bus.in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_shift_16b.sv
// Self-checking bench for shift_16b against an arithmetic reference model.
module tb_shift_16b;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    shift_16b_if bus();
    shift_16b dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference: shifts as multiplication/division by powers of two.
    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [4:0] a,
                                              input logic m, input logic dr);
        longint pw, v, q;
        int n, k;
        logic [15:0] r;
        n  = (int'(a) > 16) ? 16 : int'(a);
        pw = 1;
        for (int i = 0; i < n; i++) pw = pw * 2;
        if (!dr) begin
`ifdef SHIFT16B_ROTATE_EN
            if (m) begin
                k  = int'(a) % 16;
                pw = 1;
                for (int i = 0; i < k; i++) pw = pw * 2;
                q = (longint'(d) * pw) % 65536 + longint'(d) / (65536 / pw);
                if (k == 0) q = longint'(d);
                r = q[15:0];
                return r;
            end
`endif
            q = (longint'(d) * pw) % 65536;
        end else if (!m) begin
            q = longint'(d) / pw;
        end else begin
            v = d[15] ? longint'(d) - 65536 : longint'(d);
            q = (v >= 0) ? v / pw : -((-v + pw - 1) / pw);
        end
        r = q[15:0];
        return r;
    endfunction

    task automatic drive(input logic [15:0] d, input logic [4:0] a, input logic m,
                         input logic dr, input logic v);
        @(negedge clk);
        bus.in = d; bus.amt = a; bus.mode = m; bus.dir = dr; bus.in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in = '0; bus.amt = '0; bus.mode = 1'b0; bus.dir = 1'b0; bus.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        n_cmp++;
        if (bus.out !== 16'h0000 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_async out=%h vld=%b want 0000/0", bus.out, bus.out_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.out !== 16'h0000 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_release out=%h vld=%b want 0000/0", bus.out, bus.out_valid);
        end
    endtask

    task automatic test_sweep(input string nm, input logic [15:0] d, input logic m, input logic dr);
        logic [15:0] exp;
        for (int a = 0; a <= 16; a++) begin
            drive(d, 5'(a), m, dr, 1'b1);
            exp = ref_shift(d, 5'(a), m, dr);
            n_cmp++;
            if (bus.out !== exp || bus.out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL %s amt=%0d out=%h vld=%b want %h/1", nm, a, bus.out, bus.out_valid, exp);
            end
        end
    endtask

    task automatic test_corners();
        logic [15:0] want [6] = '{16'hC000, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h1000};
        logic [15:0] din  [6] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h4000, 16'h4000};
        logic [4:0]  am   [6] = '{5'd1, 5'd15, 5'd15, 5'd16, 5'd31, 5'd2};
        logic        md   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(din[i], am[i], md[i], 1'b1, 1'b1);
            n_cmp++;
            if (bus.out !== want[i]) begin
                n_err++; $display("FAIL corner%0d out=%h want %h", i, bus.out, want[i]);
            end
        end
        drive(16'h1234, 5'd31, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.out !== 16'h0000) begin
            n_err++; $display("FAIL left_amt31 out=%h want 0000", bus.out);
        end
    endtask

    task automatic test_reset_mid();
        drive(16'h00FF, 5'd4, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.out !== 16'h0FF0 || bus.out_valid !== 1'b1) begin
            n_err++; $display("FAIL pre_reset out=%h vld=%b want 0ff0/1", bus.out, bus.out_valid);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out !== 16'h0000 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_reset out=%h vld=%b want 0000/0", bus.out, bus.out_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.out !== 16'h0000 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_held out=%h vld=%b want 0000/0", bus.out, bus.out_valid);
        end
        @(negedge clk) begin rst_n = 1'b1; bus.in_valid = 1'b0; end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.out !== 16'h0000 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL post_reset out=%h vld=%b want 0000/0", bus.out, bus.out_valid);
        end
    endtask

    task automatic test_hold();
        drive(16'h0F0F, 5'd3, 1'b0, 1'b0, 1'b1);
        drive(16'hAAAA, 5'd1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (bus.out !== 16'h7878 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL hold out=%h vld=%b want 7878/0", bus.out, bus.out_valid);
        end
    endtask

    task automatic test_rotate();
        logic [15:0] w1, w17;
`ifdef SHIFT16B_ROTATE_EN
        w1 = 16'h0003; w17 = 16'h0003;
`else
        w1 = 16'h0002; w17 = 16'h0000;
`endif
        drive(16'h8001, 5'd1, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (bus.out !== w1) begin
            n_err++; $display("FAIL rot_amt1 out=%h want %h", bus.out, w1);
        end
        drive(16'h8001, 5'd17, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (bus.out !== w17) begin
            n_err++; $display("FAIL rot_amt17 out=%h want %h", bus.out, w17);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_out, d;
        logic [4:0]  a;
        logic        m, dr, v;
        exp_out = bus.out;
        for (int i = 0; i < 400; i++) begin
            d  = 16'($urandom);
            a  = 5'($urandom);
            m  = 1'($urandom);
            dr = 1'($urandom);
            v  = ($urandom_range(0, 3) != 0);
            drive(d, a, m, dr, v);
            if (v) exp_out = ref_shift(d, a, m, dr);
            n_cmp++;
            if (bus.out !== exp_out || bus.out_valid !== v) begin
                n_err++;
                $display("FAIL random%0d in=%h amt=%0d m=%b d=%b v=%b out=%h vld=%b want %h/%b",
                         i, d, a, m, dr, v, bus.out, bus.out_valid, exp_out, v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep("left_sweep", 16'h0001, 1'b0, 1'b0);
        test_sweep("lsr_sweep", 16'h8000, 1'b0, 1'b1);
        test_sweep("asr_sweep", 16'h8000, 1'b1, 1'b1);
        test_corners();
        test_reset_mid();
        test_hold();
        test_rotate();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
